// File: rtl/mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_arbiter (with helper int_fp_mul)                           |
// | Description : Two-requester round-robin front end sharing one int8/fp16     |
// |               multiplier. Optional per-requester result counters are built  |
// |               when MUL_ARBITER_CNT_EN is defined.                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

// Combinational multiplier. mode=0: signed a[7:0]*b[7:0] -> 16-bit product.
// mode=1: fp16 multiply, round-to-nearest-even, subnormals flushed to zero.
module int_fp_mul (
  input  logic        mode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c
);
  localparam logic [15:0] c_QNAN = 16'h7E00;

  logic [15:0]       w_int_prod;
  logic [21:0]       w_mant_prod;
  logic              w_sign;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic signed [7:0] w_exp;
  logic [10:0]       w_mant;
  logic              w_guard, w_sticky;
  logic [11:0]       w_mant_rnd;
  logic [9:0]        w_frac;
  logic [15:0]       w_fp;

  assign w_int_prod  = {{8{a[7]}}, a[7:0]} * {{8{b[7]}}, b[7:0]};
  assign w_mant_prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
  assign w_sign      = a[15] ^ b[15];
  assign w_a_nan     = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
  assign w_b_nan     = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
  assign w_a_inf     = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
  assign w_b_inf     = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
  assign w_a_zero    = (a[14:10] == 5'h00);
  assign w_b_zero    = (b[14:10] == 5'h00);

  always_comb begin
    w_exp      = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    w_mant     = w_mant_prod[20:10];
    w_guard    = w_mant_prod[9];
    w_sticky   = |w_mant_prod[8:0];
    if (w_mant_prod[21]) begin
      w_mant   = w_mant_prod[21:11];
      w_guard  = w_mant_prod[10];
      w_sticky = |w_mant_prod[9:0];
      w_exp    = w_exp + 8'sd1;
    end
    w_mant_rnd = {1'b0, w_mant} + {11'b0, (w_guard & (w_sticky | w_mant[0]))};
    w_frac     = w_mant_rnd[9:0];
    // Rounding carried out of the mantissa: value is exactly the next power of two.
    if (w_mant_rnd[11]) begin
      w_frac   = 10'd0;
      w_exp    = w_exp + 8'sd1;
    end

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_fp = c_QNAN;
    else if (w_a_inf || w_b_inf)
      w_fp = {w_sign, 5'h1F, 10'd0};
    else if (w_a_zero || w_b_zero)
      w_fp = {w_sign, 15'd0};
    else if (w_exp >= 8'sd31)
      w_fp = {w_sign, 5'h1F, 10'd0};
    else if (w_exp <= 8'sd0)
      w_fp = {w_sign, 15'd0};
    else
      w_fp = {w_sign, w_exp[4:0], w_frac};

    c = mode ? w_fp : w_int_prod;
  end
endmodule

module mul_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_id,
`ifdef MUL_ARBITER_CNT_EN
  output logic [15:0] cnt0,
  output logic [15:0] cnt1,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_id;
  logic        r_op_mode;
  logic [15:0] r_op_a, r_op_b;
  logic        r_op_id;
  logic        r_res_valid;
  logic [15:0] r_res_data;
  logic        r_res_id;
  logic        w_any_valid;
  logic        w_grant_id;
  logic        w_accept;
  logic [15:0] w_mul_c;

  int_fp_mul u_mul (
    .mode (r_op_mode),
    .a    (r_op_a),
    .b    (r_op_b),
    .c    (w_mul_c)
  );

  assign w_any_valid = req0_valid | req1_valid;
  // On a tie the requester that did not win last time is served.
  assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_id : req1_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (res_ready) begin
          if (w_any_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) w_accept = 1'b0;
  end

  assign req0_ready = w_accept & ~w_grant_id;
  assign req1_ready = w_accept &  w_grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id   <= 1'b1;
      r_op_mode   <= 1'b0;
      r_op_a      <= 16'd0;
      r_op_b      <= 16'd0;
      r_op_id     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 16'd0;
      r_res_id    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op_mode <= w_grant_id ? req1_mode : req0_mode;
        r_op_a    <= w_grant_id ? req1_a    : req0_a;
        r_op_b    <= w_grant_id ? req1_b    : req0_b;
        r_op_id   <= w_grant_id;
        r_last_id <= w_grant_id;
      end
      if (r_state == S_EXEC) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_mul_c;
        r_res_id    <= r_op_id;
      end else if (r_state == S_HOLD && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign busy      = (r_state != S_IDLE);

`ifdef MUL_ARBITER_CNT_EN
  logic [15:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else if (r_res_valid && res_ready) begin
      if (r_res_id) r_cnt1 <= r_cnt1 + 16'd1;
      else          r_cnt0 <= r_cnt0 + 16'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif
endmodule

`default_nettype wire
